// File: rtl/key_stream_gen_if.sv
// Key stream handshake bundle: seed/load control toward the generator, key word plus status back.
interface key_stream_gen_if #(
    parameter int KEY_W = 32,
    parameter int CNT_W = 11
);
    logic             load;
    logic [KEY_W-1:0] seed;
    logic             key_ready;
    logic             key_valid;
    logic [KEY_W-1:0] key;
    logic [CNT_W-1:0] key_count;
    logic             exhausted;
    logic             period_wrap;

    modport master (
        input  load, seed, key_ready,
        output key_valid, key, key_count, exhausted, period_wrap
    );

    modport slave (
        output load, seed, key_ready,
        input  key_valid, key, key_count, exhausted, period_wrap
    );
endinterface

// File: rtl/key_stream_gen.sv
// One-time-pad key source: LANES Galois LFSR lanes, seeded, warmed up, issued once each on valid/ready.
// Optional KEYGEN_REPEAT_CHECK_EN: exhaust early when any lane returns to its first-issued state.
module key_stream_gen #(
    parameter int                LANES    = 4,
    parameter int                LANE_W   = 8,
    parameter logic [LANE_W-1:0] POLY     = 8'hB8,
    parameter logic [LANE_W-1:0] ZERO_SUB = 8'h01,
    parameter int                WARMUP   = 1,
    parameter int                MAX_KEYS = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    key_stream_gen_if.master         bus
);
    localparam int KEY_W  = LANES * LANE_W;
    localparam int CNT_W  = $clog2(MAX_KEYS + 1);
    localparam int WCNT_W = $clog2(WARMUP + 1);

    typedef enum logic [1:0] {IDLE, WARM, RUN, EXHAUSTED} state_t;

    state_t            state_q;
    logic [LANE_W-1:0] lane_q    [LANES];
    logic [LANE_W-1:0] lane_nxt  [LANES];
    logic [LANE_W-1:0] lane_seed [LANES];
    logic [KEY_W-1:0]  key_w;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_inc;
    logic [WCNT_W-1:0] wcnt_q;
    logic              valid_q;
    logic              exh_q;
    logic              last_word;
    logic              wrap_hit;
    logic              xfer;

    function automatic logic [LANE_W-1:0] lfsr_step(input logic [LANE_W-1:0] s);
        return (s >> 1) ^ (s[0] ? POLY : '0);
    endfunction

    always_comb begin
        key_w = '0;
        for (int unsigned i = 0; i < LANES; i++) begin
            lane_nxt[i]  = lfsr_step(lane_q[i]);
            lane_seed[i] = bus.seed[KEY_W-1-i*LANE_W -: LANE_W];
            if (lane_seed[i] == '0)
                lane_seed[i] = ZERO_SUB;
            key_w[KEY_W-1-i*LANE_W -: LANE_W] = lane_q[i];
        end
    end

    assign xfer      = valid_q & bus.key_ready;
    assign cnt_inc   = cnt_q + 1'b1;
    assign last_word = (cnt_inc == CNT_W'(MAX_KEYS));

`ifdef KEYGEN_REPEAT_CHECK_EN
    logic [LANE_W-1:0] ref_q [LANES];
    logic              wrap_q;

    always_comb begin
        wrap_hit = 1'b0;
        for (int unsigned i = 0; i < LANES; i++)
            if (lane_nxt[i] == ref_q[i])
                wrap_hit = 1'b1;
    end

    // Reference is the first word presented in RUN, i.e. the lane state at the WARM->RUN hand-off.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < LANES; i++)
                ref_q[i] <= '0;
            wrap_q <= 1'b0;
        end else if (bus.load) begin
            wrap_q <= 1'b0;
        end else if (state_q == WARM && wcnt_q == WCNT_W'(WARMUP)) begin
            for (int unsigned i = 0; i < LANES; i++)
                ref_q[i] <= lane_q[i];
        end else if (state_q == RUN && xfer && wrap_hit) begin
            wrap_q <= 1'b1;
        end
    end

    assign bus.period_wrap = wrap_q;
`else
    assign wrap_hit        = 1'b0;
    assign bus.period_wrap = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            for (int unsigned i = 0; i < LANES; i++)
                lane_q[i] <= '0;
            cnt_q   <= '0;
            wcnt_q  <= '0;
            valid_q <= 1'b0;
            exh_q   <= 1'b0;
        end else if (bus.load) begin
            state_q <= WARM;
            for (int unsigned i = 0; i < LANES; i++)
                lane_q[i] <= lane_seed[i];
            cnt_q   <= '0;
            wcnt_q  <= '0;
            valid_q <= 1'b0;
            exh_q   <= 1'b0;
        end else begin
            case (state_q)
                WARM: begin
                    if (wcnt_q == WCNT_W'(WARMUP)) begin
                        state_q <= RUN;
                        valid_q <= 1'b1;
                    end else begin
                        for (int unsigned i = 0; i < LANES; i++)
                            lane_q[i] <= lane_nxt[i];
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end
                RUN: begin
                    if (xfer) begin
                        for (int unsigned i = 0; i < LANES; i++)
                            lane_q[i] <= lane_nxt[i];
                        cnt_q <= cnt_inc;
                        // Lanes still step on the final transfer; valid drops so that word stays hidden.
                        if (last_word || wrap_hit) begin
                            state_q <= EXHAUSTED;
                            valid_q <= 1'b0;
                            exh_q   <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.key       = key_w;
    assign bus.key_valid = valid_q;
    assign bus.key_count = cnt_q;
    assign bus.exhausted = exh_q;
endmodule
